// File: rtl/axil_seq_pkg.sv
// Shared definitions for the AXI-Lite command sequencer: FSM encoding and
// packed command/response widths.
`timescale 1ns/1ps
package axil_seq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } seq_state_e;

    // Command packs {wr, addr, wdata, wstrb}; response packs {wr, rdata, ok}.
    function automatic int cmd_w(input int aw, input int dw);
        return 1 + aw + dw + dw / 8;
    endfunction

    function automatic int rsp_w(input int dw);
        return 2 + dw;
    endfunction

    localparam int CMD_W = cmd_w(32, 32);
    localparam int RSP_W = rsp_w(32);

endpackage

// File: rtl/axil_seq_fifo.sv
// Synchronous FIFO with wrap-bit pointers; used for both the command and
// response queues of the sequencer.
`timescale 1ns/1ps
module axil_seq_fifo
    import axil_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [AW:0]      count_o
);

    logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so push+pop at full is safe.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop  ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/axil_cmd_sequencer.sv
// Buffers read/write commands, issues them one at a time to axi_lite_master
// and returns completions in order. AXIL_SEQ_STATS_EN adds completion counters.
`timescale 1ns/1ps
module axil_cmd_sequencer
    import axil_seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CMD_DEPTH  = 4,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_wr,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_wr,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_ok,
    output logic                    m_req,
    output logic                    m_wr,
    output logic [ADDR_WIDTH-1:0]   m_addr,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_ready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic                    m_resp_ok
`ifdef AXIL_SEQ_STATS_EN
    ,
    output logic [15:0]             stat_wr_cnt,
    output logic [15:0]             stat_rd_cnt,
    output logic [15:0]             stat_err_cnt
`endif
);

    localparam int SW = DATA_WIDTH / 8;
    localparam int CW = cmd_w(ADDR_WIDTH, DATA_WIDTH);
    localparam int RW = rsp_w(DATA_WIDTH);
    localparam int CA = $clog2(CMD_DEPTH);
    localparam int RA = $clog2(RSP_DEPTH);
    localparam logic [RA+1:0] RSP_LIM = RSP_DEPTH[RA+1:0];

    seq_state_e      state_q, state_d;
    logic [CW-1:0]   cmd_q, cmd_d, cmd_head;
    logic [RW-1:0]   rsp_head, rsp_in;
    logic            cmd_full, cmd_empty, rsp_full, rsp_empty;
    logic [CA:0]     cmd_count;
    logic [RA:0]     rsp_count;
    logic [RA+1:0]   rsp_used;
    logic            pending, slot_free, issue, rsp_push;
    logic            sink_unused;

    assign cmd_ready = !cmd_full;
    assign rsp_valid = !rsp_empty;

    axil_seq_fifo #(.WIDTH(CW), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (cmd_valid && cmd_ready),
        .wdata_i ({cmd_wr, cmd_addr, cmd_wdata, cmd_wstrb}),
        .pop_i   (issue),
        .rdata_o (cmd_head),
        .full_o  (cmd_full),
        .empty_o (cmd_empty),
        .count_o (cmd_count)
    );

    assign rsp_in = {m_wr, m_wr ? {DATA_WIDTH{1'b0}} : m_rdata, m_resp_ok};

    axil_seq_fifo #(.WIDTH(RW), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (rsp_push),
        .wdata_i (rsp_in),
        .pop_i   (rsp_valid && rsp_ready),
        .rdata_o (rsp_head),
        .full_o  (rsp_full),
        .empty_o (rsp_empty),
        .count_o (rsp_count)
    );

    assign rsp_wr    = rsp_head[RW-1];
    assign rsp_rdata = rsp_head[DATA_WIDTH:1];
    assign rsp_ok    = rsp_head[0];

    // A response slot is reserved before issue so the WAIT push never overflows.
    assign pending   = (state_q != IDLE);
    assign rsp_used  = {1'b0, rsp_count} + {{(RA+1){1'b0}}, pending};
    assign slot_free = (rsp_used < RSP_LIM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (!cmd_empty && slot_free) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (m_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue    = (state_q == IDLE) && !cmd_empty && slot_free;
        rsp_push = (state_q == WAIT) && m_ready;
        m_req    = (state_q == ISSUE);
    end

    // Master-side fields hold from one issue until the next.
    assign cmd_d = issue ? cmd_head : cmd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cmd_q <= '0;
        else     cmd_q <= cmd_d;
    end

    assign m_wr    = cmd_q[CW-1];
    assign m_addr  = cmd_q[CW-2 -: ADDR_WIDTH];
    assign m_wdata = cmd_q[DATA_WIDTH+SW-1 -: DATA_WIDTH];
    assign m_wstrb = cmd_q[SW-1:0];

    assign sink_unused = ^{cmd_count, rsp_full};

`ifdef AXIL_SEQ_STATS_EN
    logic [15:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        err_cnt_d = err_cnt_q;
        if (rsp_push) begin
            if (m_wr  && wr_cnt_q  != 16'hFFFF) wr_cnt_d  = wr_cnt_q + 16'd1;
            if (!m_wr && rd_cnt_q  != 16'hFFFF) rd_cnt_d  = rd_cnt_q + 16'd1;
            if (!m_resp_ok && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt_q  <= '0;
            rd_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign stat_wr_cnt  = wr_cnt_q;
    assign stat_rd_cnt  = rd_cnt_q;
    assign stat_err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_axil_cmd_sequencer.sv
// Directed bench for axil_cmd_sequencer; a small master/slave stand-in
// answers m_req after a fixed latency from a byte-strobed memory.
`timescale 1ns/1ps
module tb_axil_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_wr = 1'b0;
    logic [31:0] cmd_addr = '0, cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_wr, rsp_ok;
    logic [31:0] rsp_rdata;
    logic        m_req, m_wr, m_ready, m_resp_ok;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;
`ifdef AXIL_SEQ_STATS_EN
    logic [15:0] stat_wr_cnt, stat_rd_cnt, stat_err_cnt;
`endif

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    axil_cmd_sequencer #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .CMD_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wr(rsp_wr),
        .rsp_rdata(rsp_rdata), .rsp_ok(rsp_ok),
        .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_ready(m_ready), .m_rdata(m_rdata), .m_resp_ok(m_resp_ok)
`ifdef AXIL_SEQ_STATS_EN
        , .stat_wr_cnt(stat_wr_cnt), .stat_rd_cnt(stat_rd_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    // Master + slave stand-in: completes each request 3 cycles after m_req.
    logic [31:0] mem [0:63];
    logic        busy = 1'b0, l_wr = 1'b0, force_err = 1'b0;
    logic [31:0] l_addr = '0, l_wdata = '0;
    logic [3:0]  l_wstrb = '0, last_wr_strb = 4'hA;
    int          lat_cnt = 0;
    int          req_cnt = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ready   <= 1'b0;
            m_rdata   <= '0;
            m_resp_ok <= 1'b0;
            busy      <= 1'b0;
            lat_cnt   <= 0;
        end else begin
            m_ready <= 1'b0;
            if (m_req) begin
                busy    <= 1'b1;
                lat_cnt <= 2;
                l_wr    <= m_wr;
                l_addr  <= m_addr;
                l_wdata <= m_wdata;
                l_wstrb <= m_wstrb;
                req_cnt <= req_cnt + 1;
                if (m_wr) last_wr_strb <= m_wstrb;
            end else if (busy) begin
                if (lat_cnt == 0) begin
                    busy      <= 1'b0;
                    m_ready   <= 1'b1;
                    m_resp_ok <= !force_err;
                    if (l_wr) begin
                        m_rdata <= 32'hDEADBEEF;
                        for (int b = 0; b < 4; b++)
                            if (l_wstrb[b]) mem[l_addr[7:2]][8*b +: 8] <= l_wdata[8*b +: 8];
                    end else begin
                        m_rdata <= mem[l_addr[7:2]];
                    end
                end else begin
                    lat_cnt <= lat_cnt - 1;
                end
            end
        end
    end

    task automatic push_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, output bit waited);
        int t = 0;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        waited = !cmd_ready;
        while (!cmd_ready && t < 500) begin @(negedge clk); t++; end
        if (!cmd_ready) begin
            n_chk++; n_fail++;
            $display("FAIL push_timeout addr=%h: cmd_ready stayed 0", addr);
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic pop_rsp(output logic w, output logic [31:0] d, output logic ok);
        int t = 0;
        @(negedge clk);
        while (!rsp_valid && t < 500) begin @(negedge clk); t++; end
        if (!rsp_valid) begin
            n_chk++; n_fail++;
            $display("FAIL rsp_timeout: rsp_valid stayed 0");
        end
        w = rsp_wr; d = rsp_rdata; ok = rsp_ok;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_chk++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready got %b exp 1", cmd_ready); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rsp_valid got %b exp 0", rsp_valid); end
        n_chk++; if ({m_req, m_wr, m_wstrb} !== 6'b0) begin n_fail++; $display("FAIL rst_req_wr_strb got %b exp 0", {m_req, m_wr, m_wstrb}); end
        n_chk++; if (m_addr !== 32'h0) begin n_fail++; $display("FAIL rst_m_addr got %h exp 0", m_addr); end
        n_chk++; if (m_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_m_wdata got %h exp 0", m_wdata); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit w_; logic w, ok; logic [31:0] d;
        push_cmd(1'b1, 32'h10, 32'hCAFEBABE, 4'hF, w_);
        @(negedge clk);
        n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL lat_req_early got %b exp 0", m_req); end
        @(negedge clk);
        n_chk++; if ({m_req, m_wr, m_addr, m_wdata, m_wstrb} !== {1'b1, 1'b1, 32'h10, 32'hCAFEBABE, 4'hF}) begin
            n_fail++; $display("FAIL issue_fields got req=%b wr=%b addr=%h data=%h strb=%h", m_req, m_wr, m_addr, m_wdata, m_wstrb);
        end
        @(negedge clk);
        n_chk++; if (m_req !== 1'b0) begin n_fail++; $display("FAIL req_one_cycle got %b exp 0", m_req); end
        push_cmd(1'b0, 32'h10, 32'h0, 4'h0, w_);
        pop_rsp(w, d, ok);
        n_chk++; if ({w, d, ok} !== {1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL basic_wr_rsp got wr=%b d=%h ok=%b exp 1/0/1", w, d, ok); end
        pop_rsp(w, d, ok);
        n_chk++; if ({w, d, ok} !== {1'b0, 32'hCAFEBABE, 1'b1}) begin n_fail++; $display("FAIL basic_rd_rsp got wr=%b d=%h ok=%b exp 0/cafebabe/1", w, d, ok); end
    endtask

    task automatic test_back_to_back();
        bit waited; int first_stall = -1; logic w, ok; logic [31:0] d;
        for (int i = 0; i < 8; i++) begin
            push_cmd(1'b1, i * 4, 32'hA0000000 + i, 4'hF, waited);
            if (waited && first_stall < 0) first_stall = i;
        end
        // Four entries fill the FIFO plus one already taken by the first issue.
        n_chk++; if (first_stall != 5) begin n_fail++; $display("FAIL b2b_first_stall got %0d exp 5", first_stall); end
        for (int i = 0; i < 8; i++) begin
            pop_rsp(w, d, ok);
            n_chk++; if ({w, d, ok} !== {1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL b2b_wr_rsp%0d got wr=%b d=%h ok=%b", i, w, d, ok); end
        end
        for (int i = 0; i < 8; i++) push_cmd(1'b0, i * 4, 32'h0, 4'h0, waited);
        for (int i = 0; i < 8; i++) begin
            pop_rsp(w, d, ok);
            n_chk++; if ({w, d, ok} !== {1'b0, 32'hA0000000 + i, 1'b1}) begin n_fail++; $display("FAIL b2b_rd_rsp%0d got wr=%b d=%h ok=%b exp data %h", i, w, d, ok, 32'hA0000000 + i); end
        end
    endtask

    task automatic test_rsp_stall();
        bit w_; logic w, ok; logic [31:0] d; int r0;
        r0 = req_cnt;
        for (int i = 0; i < 6; i++) push_cmd(1'b0, i * 4, 32'h0, 4'h0, w_);
        repeat (60) @(negedge clk);
        n_chk++; if (req_cnt - r0 != 4) begin n_fail++; $display("FAIL stall_req_count got %0d exp 4", req_cnt - r0); end
        n_chk++; if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_rsp_valid got %b exp 1", rsp_valid); end
        for (int i = 0; i < 6; i++) begin
            pop_rsp(w, d, ok);
            n_chk++; if ({w, d, ok} !== {1'b0, 32'hA0000000 + i, 1'b1}) begin n_fail++; $display("FAIL stall_rd_rsp%0d got wr=%b d=%h ok=%b", i, w, d, ok); end
        end
        n_chk++; if (req_cnt - r0 != 6) begin n_fail++; $display("FAIL stall_total_req got %0d exp 6", req_cnt - r0); end
    endtask

    task automatic test_wstrb();
        bit w_; logic w, ok; logic [31:0] d;
        push_cmd(1'b1, 32'h20, 32'h00000000, 4'hF, w_);
        push_cmd(1'b1, 32'h20, 32'h000000FF, 4'h1, w_);
        push_cmd(1'b1, 32'h20, 32'h12345678, 4'h0, w_);
        push_cmd(1'b0, 32'h20, 32'h0, 4'hF, w_);
        for (int i = 0; i < 3; i++) begin
            pop_rsp(w, d, ok);
            n_chk++; if ({w, d, ok} !== {1'b1, 32'h0, 1'b1}) begin n_fail++; $display("FAIL strb_wr_rsp%0d got wr=%b d=%h ok=%b", i, w, d, ok); end
        end
        pop_rsp(w, d, ok);
        n_chk++; if ({w, d, ok} !== {1'b0, 32'h000000FF, 1'b1}) begin n_fail++; $display("FAIL strb_rd_rsp got wr=%b d=%h ok=%b exp 0/000000ff/1", w, d, ok); end
        n_chk++; if (last_wr_strb !== 4'h0) begin n_fail++; $display("FAIL strb_zero_fwd got %h exp 0", last_wr_strb); end
    endtask

    task automatic test_reset_mid();
        bit w_; logic w, ok; logic [31:0] d; int r0; int t = 0;
        r0 = req_cnt;
        push_cmd(1'b1, 32'h30, 32'h1, 4'hF, w_);
        push_cmd(1'b1, 32'h34, 32'h2, 4'hF, w_);
        push_cmd(1'b1, 32'h38, 32'h3, 4'hF, w_);
        while (req_cnt - r0 < 1 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        n_chk++; if (m_req !== 1'b0 || m_ready !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL mid_pre_wait req=%b ready=%b cmd_ready=%b exp 0/0/1", m_req, m_ready, cmd_ready);
        end
        rst = 1'b1;
        #1;
        n_chk++; if ({m_req, rsp_valid, cmd_ready} !== 3'b001) begin n_fail++; $display("FAIL mid_rst_outputs got req/rspv/cmdr=%b exp 001", {m_req, rsp_valid, cmd_ready}); end
        n_chk++; if ({m_wr, m_addr, m_wdata} !== 65'h0) begin n_fail++; $display("FAIL mid_rst_fields got wr=%b addr=%h data=%h exp 0", m_wr, m_addr, m_wdata); end
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_chk++; if (rsp_valid !== 1'b0 || req_cnt - r0 != 1) begin n_fail++; $display("FAIL mid_discard rsp_valid=%b reqs=%0d exp 0/1", rsp_valid, req_cnt - r0); end
        push_cmd(1'b0, 32'h20, 32'h0, 4'h0, w_);
        pop_rsp(w, d, ok);
        n_chk++; if ({w, d, ok} !== {1'b0, 32'h000000FF, 1'b1}) begin n_fail++; $display("FAIL mid_after_rst got wr=%b d=%h ok=%b exp 0/000000ff/1", w, d, ok); end
    endtask

`ifdef AXIL_SEQ_STATS_EN
    task automatic test_stats();
        bit w_; logic w, ok; logic [31:0] d;
        @(negedge clk); rst = 1'b1; @(negedge clk); rst = 1'b0;
        n_chk++; if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== 48'h0) begin n_fail++; $display("FAIL stats_reset got %h/%h/%h", stat_wr_cnt, stat_rd_cnt, stat_err_cnt); end
        for (int i = 0; i < 3; i++) push_cmd(1'b1, 32'h40 + i * 4, 32'h100 + i, 4'hF, w_);
        for (int i = 0; i < 2; i++) push_cmd(1'b0, 32'h40 + i * 4, 32'h0, 4'h0, w_);
        for (int i = 0; i < 5; i++) pop_rsp(w, d, ok);
        n_chk++; if ({stat_wr_cnt, stat_rd_cnt, stat_err_cnt} !== {16'd3, 16'd2, 16'd0}) begin n_fail++; $display("FAIL stats_counts got %0d/%0d/%0d exp 3/2/0", stat_wr_cnt, stat_rd_cnt, stat_err_cnt); end
        force_err = 1'b1;
        push_cmd(1'b0, 32'h40, 32'h0, 4'h0, w_);
        pop_rsp(w, d, ok);
        force_err = 1'b0;
        n_chk++; if (ok !== 1'b0) begin n_fail++; $display("FAIL stats_err_rsp got ok=%b exp 0", ok); end
        n_chk++; if ({stat_rd_cnt, stat_err_cnt} !== {16'd3, 16'd1}) begin n_fail++; $display("FAIL stats_err_cnt got rd=%0d err=%0d exp 3/1", stat_rd_cnt, stat_err_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_rsp_stall();
        test_wstrb();
        test_reset_mid();
`ifdef AXIL_SEQ_STATS_EN
        test_stats();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
